fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage. It drives the PC and the instruction-memory request, and it fills the IF/ID register that feeds the opcode/condition decoder. It consumes the decoder's redirect (PCctrl with target address), the EXEC request and the pipeline stall. It sequences the single-instruction EXEC detour and the return to the instruction after EXEC.

Parameters:
ISIZE, 16, instruction width
ASIZE, 16, PC / instruction address width
RESET_PC, 16'h0000, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted at 0)
stall  in  1  hold IF/ID and PC (load-use hazard)
pc_ctrl  in  1  redirect request from decoder (taken B / JAL / JR)
redirect_addr  in  ASIZE  redirect target
exec_req  in  1  EXEC instruction currently in decode
exec_addr  in  ASIZE  address of the instruction to execute
imem_req  out  1  instruction-memory read request
imem_addr  out  ASIZE  read address (= PC register)
imem_ack  in  1  data valid for current imem_addr; may arrive in the same cycle as req
imem_data  in  ISIZE  instruction word
instr_out  out  ISIZE  IF/ID instruction
pc_out  out  ASIZE  IF/ID link PC (address of instr_out + 1)
instr_valid  out  1  IF/ID holds a real instruction
exec_slot  out  1  instr_out is the EXEC target instruction

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, ret_pc=0, state=FETCH.
  - instr_out=0, pc_out=0, instr_valid=0, exec_slot=0.
  - imem_req=0 while rst=0.
- States: FETCH (normal sequential fetch) and EXEC (fetch one instruction at exec_addr, then return).
- imem_req = rst & ~stall & ~pc_ctrl & ~exec_req (combinational). imem_addr = pc.
- Memory handshake:
  - Memory returns data for the address presented in the ack cycle.
  - imem_ack is ignored whenever imem_req=0.
  - Wait states are allowed: while req=1 and ack=0, pc holds and IF/ID loads a bubble (instr_valid=0, instr_out=0) unless stall=1.
- Priority per cycle: pc_ctrl > exec_req > stall > normal.
- pc_ctrl=1:
  - pc<=redirect_addr, state<=FETCH. Any EXEC in progress is aborted.
  - IF/ID<=bubble (instr_valid=0, instr_out=0, exec_slot=0); the fetched word is discarded.
- exec_req=1 (pc_ctrl=0), only honoured in FETCH:
  - ret_pc<=pc_out (EXEC's own address + 1).
  - pc<=exec_addr, state<=EXEC, IF/ID<=bubble.
  - exec_req in EXEC state is ignored.
- stall=1 (no redirect/exec): pc, IF/ID, state and ret_pc all hold; no request is issued.
- FETCH, ack=1:
  - instr_out<=imem_data, pc_out<=pc+1, instr_valid<=1, exec_slot<=0.
  - pc<=pc+1. This gives one instruction per cycle with a zero-wait memory.
- EXEC, ack=1:
  - instr_out<=imem_data, pc_out<=ret_pc (so a JAL target links past EXEC), instr_valid<=1, exec_slot<=1.
  - pc<=ret_pc, state<=FETCH.
- Arithmetic: pc+1 is modulo 2^ASIZE, so 16'hFFFF+1 = 16'h0000 with no flag.
- An EXEC target that is itself EXEC: a new exec_req in the following decode cycle is honoured. ret_pc<=pc_out, which equals the original ret_pc, so the return address is preserved.
- Reset mid-EXEC or mid-wait: everything returns to reset values immediately; no pending state survives.

Test Plan:
1. Reset release, zero-wait memory, mem[k]=16'h1000+k:
   - Required: cycles 1..4 give instr_out 1000,1001,1002,1003 with pc_out 1,2,3,4, instr_valid=1, imem_addr 0→4.
2. Memory with 2 wait states at addr 2:
   - Required: two bubbles (instr_valid=0, instr_out=0), then instr_out=1002; pc holds at 2 during the wait.
3. stall=1 for 3 cycles with IF/ID=1005:
   - Required: instr_out stays 1005, imem_req=0, pc constant.
   - After release, the next instruction is 1006 with no duplicate or skip.
4. pc_ctrl=1, redirect_addr=16'h0040, asserted in the same cycle as ack:
   - Required: next IF/ID is a bubble, then 1040 with pc_out=16'h0041; the acked word is discarded.
5. exec_req with exec_addr=16'h0080, EXEC at 16'h0010 (pc_out=16'h0011):
   - Required: bubble, then instr_out=1080 with exec_slot=1 and pc_out=16'h0011.
   - Then 1011 with exec_slot=0.
6. Boundary cases:
   - pc=16'hFFFF: the fetch sets pc to 16'h0000.
   - pc_ctrl and exec_req together: the redirect wins and state stays FETCH.
   - rst=0 during EXEC wait: all outputs reset within the same cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC sequencing, instruction-memory request and the
// IF/ID register, including the single-instruction EXEC detour and return.
module fetch_unit #(
  parameter int unsigned         ISIZE    = 16,
  parameter int unsigned         ASIZE    = 16,
  parameter logic [ASIZE-1:0]    RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             pc_ctrl,
  input  logic [ASIZE-1:0] redirect_addr,
  input  logic             exec_req,
  input  logic [ASIZE-1:0] exec_addr,
  output logic             imem_req,
  output logic [ASIZE-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [ISIZE-1:0] imem_data,
  output logic [ISIZE-1:0] instr_out,
  output logic [ASIZE-1:0] pc_out,
  output logic             instr_valid,
  output logic             exec_slot
);

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_EXEC  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [ASIZE-1:0] pc_q, pc_d;
  logic [ASIZE-1:0] ret_pc_q, ret_pc_d;
  logic [ISIZE-1:0] instr_q, instr_d;
  logic [ASIZE-1:0] pc_out_q, pc_out_d;
  logic             valid_q, valid_d;
  logic             exec_slot_q, exec_slot_d;

  // Request is withheld whenever this cycle's fetch would be discarded or held.
  assign imem_req  = rst & ~stall & ~pc_ctrl & ~exec_req;
  assign imem_addr = pc_q;

  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  assign exec_slot   = exec_slot_q;

  // Next-state: redirect > exec > stall > fetch/wait.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ret_pc_d    = ret_pc_q;
    instr_d     = instr_q;
    pc_out_d    = pc_out_q;
    valid_d     = valid_q;
    exec_slot_d = exec_slot_q;

    if (pc_ctrl) begin
      pc_d        = redirect_addr;
      state_d     = ST_FETCH;
      instr_d     = '0;
      valid_d     = 1'b0;
      exec_slot_d = 1'b0;
    end else if (exec_req && (state_q == ST_FETCH)) begin
      ret_pc_d    = pc_out_q;
      pc_d        = exec_addr;
      state_d     = ST_EXEC;
      instr_d     = '0;
      valid_d     = 1'b0;
      exec_slot_d = 1'b0;
    end else if (stall) begin
      state_d = state_q;
    end else if (imem_req && imem_ack) begin
      instr_d = imem_data;
      valid_d = 1'b1;
      if (state_q == ST_EXEC) begin
        // Link PC points past the EXEC instruction, not past the target.
        pc_out_d    = ret_pc_q;
        exec_slot_d = 1'b1;
        pc_d        = ret_pc_q;
        state_d     = ST_FETCH;
      end else begin
        pc_out_d    = pc_q + ASIZE'(1);
        exec_slot_d = 1'b0;
        pc_d        = pc_q + ASIZE'(1);
      end
    end else begin
      instr_d     = '0;
      valid_d     = 1'b0;
      exec_slot_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      ret_pc_q    <= '0;
      instr_q     <= '0;
      pc_out_q    <= '0;
      valid_q     <= 1'b0;
      exec_slot_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ret_pc_q    <= ret_pc_d;
      instr_q     <= instr_d;
      pc_out_q    <= pc_out_d;
      valid_q     <= valid_d;
      exec_slot_q <= exec_slot_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural fetch model checked every cycle, plus
// directed literal expectations for each scenario.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, pc_ctrl, exec_req;
  logic [15:0] redirect_addr, exec_addr;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr, imem_data;
  logic [15:0] instr_out, pc_out;
  logic        instr_valid, exec_slot;

  int vectors = 0;
  int miscompares = 0;

  // Memory: word = 16'h1000 + address, with optional wait states at one address.
  logic [15:0] wait_addr = 16'hFFFF;
  int          wait_n = 0;
  int          wait_cnt;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] base;
    base = 16'h1000;
    return base + a;
  endfunction

  function automatic logic mem_ready(input logic [15:0] a, input int cnt);
    return !(a == wait_addr && cnt < wait_n);
  endfunction

  always_comb imem_data = mem_word(imem_addr);
  always_comb imem_ack  = mem_ready(imem_addr, wait_cnt);

  always @(posedge clk or negedge rst)
    if (!rst) wait_cnt <= 0;
    else      wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_ctrl(pc_ctrl),
    .redirect_addr(redirect_addr), .exec_req(exec_req), .exec_addr(exec_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .instr_out(instr_out), .pc_out(pc_out),
    .instr_valid(instr_valid), .exec_slot(exec_slot)
  );

  always #5 clk = ~clk;

  // Reference model: where the fetch stage is and what IF/ID must hold.
  logic [15:0] m_pc, m_ret, m_instr, m_pcout;
  logic        m_in_exec, m_valid, m_slot;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc <= 16'h0000; m_ret <= 16'h0000; m_in_exec <= 1'b0;
      m_instr <= 16'h0000; m_pcout <= 16'h0000; m_valid <= 1'b0; m_slot <= 1'b0;
    end else if (pc_ctrl) begin
      m_pc <= redirect_addr; m_in_exec <= 1'b0;
      m_instr <= 16'h0000; m_valid <= 1'b0; m_slot <= 1'b0;
    end else if (exec_req && !m_in_exec) begin
      m_ret <= m_pcout; m_pc <= exec_addr; m_in_exec <= 1'b1;
      m_instr <= 16'h0000; m_valid <= 1'b0; m_slot <= 1'b0;
    end else if (exec_req || (!stall && !mem_ready(m_pc, wait_cnt))) begin
      m_instr <= 16'h0000; m_valid <= 1'b0; m_slot <= 1'b0;
    end else if (!stall) begin
      m_instr <= mem_word(m_pc); m_valid <= 1'b1; m_slot <= m_in_exec;
      m_pcout <= m_in_exec ? m_ret : 16'(m_pc + 16'd1);
      m_pc    <= m_in_exec ? m_ret : 16'(m_pc + 16'd1);
      m_in_exec <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the clock edge.
  always @(posedge clk) begin
    #2;
    chk("m_req", 16'(imem_req), 16'(rst & ~stall & ~pc_ctrl & ~exec_req));
    chk("m_addr", imem_addr, m_pc);
    chk("m_instr", instr_out, m_instr);
    chk("m_valid", 16'(instr_valid), 16'(m_valid));
    chk("m_slot", 16'(exec_slot), 16'(m_slot));
    if (m_valid) chk("m_pcout", pc_out, m_pcout);
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic chk_ifid(input string name, input logic [15:0] i, input logic [15:0] p,
                          input logic v, input logic s);
    chk({name, "_instr"}, instr_out, i);
    chk({name, "_valid"}, 16'(instr_valid), 16'(v));
    chk({name, "_slot"}, 16'(exec_slot), 16'(s));
    if (v) chk({name, "_pcout"}, pc_out, p);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; stall = 1'b0; pc_ctrl = 1'b0; exec_req = 1'b0;
    redirect_addr = 16'h0000; exec_addr = 16'h0000;
    step(); step();
    chk_ifid("reset", 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("reset_req", 16'(imem_req), 16'h0000);
    chk("reset_addr", imem_addr, 16'h0000);

    // 1: zero-wait sequential fetch from reset.
    rst = 1'b1;
    #1 chk("t1_req", 16'(imem_req), 16'h0001);
    chk("t1_addr0", imem_addr, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_ifid("t1", 16'(16'h1000 + k), 16'(k + 1), 1'b1, 1'b0);
      chk("t1_addr", imem_addr, 16'(k + 1));
    end

    // 2: two wait states at address 2.
    rst = 1'b0; step();
    wait_addr = 16'h0002; wait_n = 2; rst = 1'b1;
    step(); step();
    chk_ifid("t2_pre", 16'h1001, 16'h0002, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk_ifid("t2_wait", 16'h0000, 16'h0000, 1'b0, 1'b0);
      chk("t2_addr", imem_addr, 16'h0002);
    end
    step();
    chk_ifid("t2_done", 16'h1002, 16'h0003, 1'b1, 1'b0);
    wait_n = 0;
    step(); step(); step();
    chk_ifid("t3_pre", 16'h1005, 16'h0006, 1'b1, 1'b0);

    // 3: three-cycle stall holds IF/ID and PC.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_ifid("t3_stall", 16'h1005, 16'h0006, 1'b1, 1'b0);
      chk("t3_req", 16'(imem_req), 16'h0000);
      chk("t3_addr", imem_addr, 16'h0006);
    end
    stall = 1'b0;
    step();
    chk_ifid("t3_after", 16'h1006, 16'h0007, 1'b1, 1'b0);

    // 4: redirect while memory acks; the acked word is dropped.
    pc_ctrl = 1'b1; redirect_addr = 16'h0040;
    #1 chk("t4_ack", 16'(imem_ack), 16'h0001);
    step(); pc_ctrl = 1'b0;
    chk_ifid("t4_bubble", 16'h0000, 16'h0000, 1'b0, 1'b0);
    step();
    chk_ifid("t4_target", 16'h1040, 16'h0041, 1'b1, 1'b0);

    // 5: EXEC at 0x0010 targeting 0x0080.
    pc_ctrl = 1'b1; redirect_addr = 16'h0010;
    step(); pc_ctrl = 1'b0;
    step();
    chk_ifid("t5_exec", 16'h1010, 16'h0011, 1'b1, 1'b0);
    exec_req = 1'b1; exec_addr = 16'h0080;
    step(); exec_req = 1'b0;
    chk_ifid("t5_bubble", 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("t5_addr", imem_addr, 16'h0080);
    step();
    chk_ifid("t5_slot", 16'h1080, 16'h0011, 1'b1, 1'b1);
    step();
    chk_ifid("t5_ret", 16'h1011, 16'h0012, 1'b1, 1'b0);

    // exec_req held into EXEC is ignored; nested EXEC keeps the return address.
    exec_req = 1'b1; exec_addr = 16'h0090;
    step(); exec_addr = 16'h0099;
    step(); exec_req = 1'b0;
    chk("t5_ign_addr", imem_addr, 16'h0090);
    step();
    chk_ifid("t5_ign", 16'h1090, 16'h0012, 1'b1, 1'b1);
    exec_req = 1'b1; exec_addr = 16'h00A0;
    step(); exec_req = 1'b0;
    step();
    chk_ifid("t5_nest", 16'h10A0, 16'h0012, 1'b1, 1'b1);
    step();
    chk_ifid("t5_nest_ret", 16'h1012, 16'h0013, 1'b1, 1'b0);

    // 6a: PC wrap at 0xFFFF.
    pc_ctrl = 1'b1; redirect_addr = 16'hFFFF;
    step(); pc_ctrl = 1'b0;
    step();
    chk_ifid("t6_wrap", 16'h0FFF, 16'h0000, 1'b1, 1'b0);
    chk("t6_wrap_addr", imem_addr, 16'h0000);

    // 6b: redirect beats a simultaneous exec_req.
    pc_ctrl = 1'b1; redirect_addr = 16'h0030; exec_req = 1'b1; exec_addr = 16'h0080;
    step(); pc_ctrl = 1'b0; exec_req = 1'b0;
    chk("t6_prio_addr", imem_addr, 16'h0030);
    step();
    chk_ifid("t6_prio", 16'h1030, 16'h0031, 1'b1, 1'b0);

    // 6c: reset during an EXEC wait state.
    wait_addr = 16'h0050; wait_n = 5;
    exec_req = 1'b1; exec_addr = 16'h0050;
    step(); exec_req = 1'b0;
    step();
    chk_ifid("t6_wait", 16'h0000, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk_ifid("t6_rst", 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("t6_rst_pcout", pc_out, 16'h0000);
    chk("t6_rst_addr", imem_addr, 16'h0000);
    chk("t6_rst_req", 16'(imem_req), 16'h0000);
    step();
    wait_n = 0; rst = 1'b1;
    step();
    chk_ifid("t6_restart", 16'h1000, 16'h0001, 1'b1, 1'b0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
